// File: rtl/trace_record_buffer_if.sv
// trace_record_buffer_if
// Groups the record input (formatter side) and the record stream output
// (sink side) of trace_record_buffer, plus its occupancy/drop status.
// master: the environment (formatter + sink); slave: the buffer itself.
interface trace_record_buffer_if #(
   parameter int AXIAddrWidth   = 64,
   parameter int TimestampWidth = 32,
   parameter int DepthLog2      = 4,
   parameter int DropCountWidth = 16
);

   logic [AXIAddrWidth-1:0]   in_addr;
   logic [TimestampWidth-1:0] in_timestamp;
   logic                      in_valid;

   logic [AXIAddrWidth-1:0]   out_addr;
   logic [TimestampWidth-1:0] out_timestamp;
   logic                      out_marker;
   logic                      out_valid;
   logic                      out_ready;

   logic [DepthLog2:0]        level;
   logic [DropCountWidth-1:0] drop_count;

   modport master (
      output in_addr, in_timestamp, in_valid, out_ready,
      input  out_addr, out_timestamp, out_marker, out_valid, level, drop_count
   );

   modport slave (
      input  in_addr, in_timestamp, in_valid, out_ready,
      output out_addr, out_timestamp, out_marker, out_valid, level, drop_count
   );

endinterface

// File: rtl/trace_record_buffer.sv
// trace_record_buffer
// Absorbs AW trace records (address + timestamp) arriving as single-cycle
// pulses with no backpressure and presents them as a first-word-fall-through
// valid/ready stream. Records arriving while the FIFO is full (and no pop is
// freeing a slot) are dropped and counted in a saturating drop counter.
//
// Optional feature, enabled by defining TRACE_BUF_DROP_MARKER_EN:
// after a drop, a marker record (out_marker=1, addr=0, timestamp=number of
// records dropped since the previous marker) is inserted into the stream on
// the first cycle with no incoming record and a free slot. Without the macro,
// out_marker is tied low and no marker state exists.
module trace_record_buffer #(
   parameter int AXIAddrWidth   = 64,
   parameter int TimestampWidth = 32,
   parameter int DepthLog2      = 4,
   parameter int DropCountWidth = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   trace_record_buffer_if.slave  bus
);

   localparam int                 Depth    = 1 << DepthLog2;
   localparam logic [DepthLog2:0] DepthLvl = (DepthLog2 + 1)'(Depth);
   localparam logic [DepthLog2:0] LvlOne   = (DepthLog2 + 1)'(1);
   localparam logic [DepthLog2-1:0] PtrOne = DepthLog2'(1);
   localparam logic [DropCountWidth-1:0] DropMax = {DropCountWidth{1'b1}};
   localparam logic [DropCountWidth-1:0] DropOne = DropCountWidth'(1);

   // Record storage; intentionally not reset, occupancy is tracked by level_r.
   logic [AXIAddrWidth-1:0]   addr_mem_r [Depth];
   logic [TimestampWidth-1:0] ts_mem_r   [Depth];

   logic [DepthLog2-1:0]      wr_ptr_r;
   logic [DepthLog2-1:0]      rd_ptr_r;
   logic [DepthLog2:0]        level_r;
   logic                      out_valid_r;
   logic [DropCountWidth-1:0] drop_count_r;

   logic                      pop_s;
   logic                      slot_free_s;
   logic                      push_s;
   logic                      drop_s;
   logic                      wr_en_s;
   logic [AXIAddrWidth-1:0]   wr_addr_s;
   logic [TimestampWidth-1:0] wr_ts_s;
   logic [DepthLog2:0]        level_nxt_s;

   // Handshake decode: a slot is usable if the FIFO is not full or the head leaves this cycle.
   always_comb begin
      pop_s       = out_valid_r & bus.out_ready;
      slot_free_s = (level_r != DepthLvl) | pop_s;
      push_s      = bus.in_valid & slot_free_s;
      drop_s      = bus.in_valid & ~slot_free_s;
   end

`ifdef TRACE_BUF_DROP_MARKER_EN

   localparam int MarkWidth = (DropCountWidth > TimestampWidth) ? DropCountWidth : TimestampWidth;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWED = 1'b1
   } marker_state_e;

   marker_state_e             state_r;
   marker_state_e             state_nxt_s;
   logic [DropCountWidth-1:0] interval_r;
   logic                      marker_wr_s;
   logic                      wr_marker_s;
   logic                      mk_mem_r [Depth];

   // Marker timestamp: interval count zero-extended, or all-ones if it does not fit.
   function automatic logic [TimestampWidth-1:0] marker_ts(input logic [DropCountWidth-1:0] cnt);
      logic [MarkWidth-1:0] wide;
      logic [MarkWidth-1:0] lim;
      wide = MarkWidth'(cnt);
      lim  = MarkWidth'({TimestampWidth{1'b1}});
      if (wide > lim) begin
         marker_ts = {TimestampWidth{1'b1}};
      end else begin
         marker_ts = TimestampWidth'(wide);
      end
   endfunction

   // Marker FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Marker FSM next state: owe a marker after any drop, emit it on an idle input cycle with a free slot.
   always_comb begin
      state_nxt_s = state_r;
      marker_wr_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (drop_s) begin
               state_nxt_s = OWED;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         OWED: begin
            if (!bus.in_valid && slot_free_s) begin
               marker_wr_s = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OWED;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Drops since the last marker, saturating; cleared when the marker is written.
   always_ff @(posedge clk) begin
      if (reset) begin
         interval_r <= {DropCountWidth{1'b0}};
      end else if (marker_wr_s) begin
         interval_r <= {DropCountWidth{1'b0}};
      end else if (drop_s && (interval_r != DropMax)) begin
         interval_r <= interval_r + DropOne;
      end
   end

   // Write-data select: real record, or the pending marker when no record arrives.
   always_comb begin
      wr_en_s = push_s | marker_wr_s;
      if (marker_wr_s) begin
         wr_addr_s   = {AXIAddrWidth{1'b0}};
         wr_ts_s     = marker_ts(interval_r);
         wr_marker_s = 1'b1;
      end else begin
         wr_addr_s   = bus.in_addr;
         wr_ts_s     = bus.in_timestamp;
         wr_marker_s = 1'b0;
      end
   end

   // Per-entry marker flag storage.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mk_mem_r[wr_ptr_r] <= wr_marker_s;
      end
   end

   assign bus.out_marker = mk_mem_r[rd_ptr_r];

`else

   // Write-data select: only real records enter the FIFO.
   always_comb begin
      wr_en_s   = push_s;
      wr_addr_s = bus.in_addr;
      wr_ts_s   = bus.in_timestamp;
   end

   assign bus.out_marker = 1'b0;

`endif

   // Record storage write at the tail.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         addr_mem_r[wr_ptr_r] <= wr_addr_s;
         ts_mem_r[wr_ptr_r]   <= wr_ts_s;
      end
   end

   // Next occupancy: push and pop together leave the level unchanged.
   always_comb begin
      case ({wr_en_s, pop_s})
         2'b10:   level_nxt_s = level_r + LvlOne;
         2'b01:   level_nxt_s = level_r - LvlOne;
         default: level_nxt_s = level_r;
      endcase
   end

   // Pointers, level and registered out_valid; pointers wrap modulo depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r    <= {DepthLog2{1'b0}};
         rd_ptr_r    <= {DepthLog2{1'b0}};
         level_r     <= {(DepthLog2 + 1){1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PtrOne;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrOne;
         end
         level_r     <= level_nxt_s;
         out_valid_r <= (level_nxt_s != {(DepthLog2 + 1){1'b0}});
      end
   end

   // Cumulative drop counter, holding at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count_r <= {DropCountWidth{1'b0}};
      end else if (drop_s && (drop_count_r != DropMax)) begin
         drop_count_r <= drop_count_r + DropOne;
      end
   end

   assign bus.out_addr      = addr_mem_r[rd_ptr_r];
   assign bus.out_timestamp = ts_mem_r[rd_ptr_r];
   assign bus.out_valid     = out_valid_r;
   assign bus.level         = level_r;
   assign bus.drop_count    = drop_count_r;

endmodule
